// File: rtl/axi4_lite_pkg.sv
// Shared types and constants for AXI4-Lite blocks: bus configuration,
// response codes and the state encodings of the terminus FSMs.
package axi4_lite_pkg;

  typedef struct packed {
    int A;       // address width in bits
    int N;       // data width in bytes
    int ID_W;    // reserved for future use, keep 0
    int USER_W;  // reserved for future use, keep 0
  } axi4_lite_cfg_t;

  localparam axi4_lite_cfg_t AXI4_LITE_CFG_DEFAULT = '{default: 0, A: 16, N: 4};

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_WAIT_W  = 2'd1,
    W_WAIT_AW = 2'd2,
    W_RESP    = 2'd3
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  function automatic int cfg_data_bits(axi4_lite_cfg_t c);
    return 8 * c.N;
  endfunction

endpackage

// File: rtl/axi4_lite_if.sv
// AXI4-Lite bus bundle carrying its own clock and reset, with master and
// slave views.
interface axi4_lite_if #(
  parameter axi4_lite_pkg::axi4_lite_cfg_t C = axi4_lite_pkg::AXI4_LITE_CFG_DEFAULT
) (
  input logic aclk,
  input logic areset
);

  localparam int AW = C.A;
  localparam int DW = axi4_lite_pkg::cfg_data_bits(C);
  localparam int SW = C.N;

  logic [AW-1:0] awaddr;
  logic [2:0]    awprot;
  logic          awvalid;
  logic          awready;

  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wvalid;
  logic          wready;

  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;

  logic [AW-1:0] araddr;
  logic [2:0]    arprot;
  logic          arvalid;
  logic          arready;

  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;

  modport master (
    input  aclk, areset,
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  aclk, areset,
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/axi4_lite_terminus.sv
// AXI4-Lite sink: accepts every access, drops write data, answers reads with
// zeros. Independent read and write FSMs, all outputs straight from flops.
module axi4_lite_terminus
  import axi4_lite_pkg::*;
#(
  parameter axi4_lite_cfg_t C = AXI4_LITE_CFG_DEFAULT
) (
  input logic       aclk,
  input logic       areset,
  axi4_lite_if.slave axi4_s
);

  localparam int DW = cfg_data_bits(C);

  // Address, data, strobes and prot carry no meaning for a terminus.
  logic unused_inputs;
  assign unused_inputs = ^{axi4_s.awaddr, axi4_s.awprot, axi4_s.wdata, axi4_s.wstrb,
                           axi4_s.araddr, axi4_s.arprot, axi4_s.aclk, axi4_s.areset};

  w_state_e      w_state_q, w_state_d;
  logic          awready_q, awready_d;
  logic          wready_q, wready_d;
  logic          bvalid_q, bvalid_d;
  logic [1:0]    bresp_q, bresp_d;

  r_state_e      r_state_q, r_state_d;
  logic          arready_q, arready_d;
  logic          rvalid_q, rvalid_d;
  logic [1:0]    rresp_q, rresp_d;
  logic [DW-1:0] rdata_q, rdata_d;

  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign aw_hs = axi4_s.awvalid & awready_q;
  assign w_hs  = axi4_s.wvalid  & wready_q;
  assign b_hs  = bvalid_q       & axi4_s.bready;
  assign ar_hs = axi4_s.arvalid & arready_q;
  assign r_hs  = rvalid_q       & axi4_s.rready;

  // Write channel: outputs are decoded from the next state and registered,
  // so readies stay low during reset and bvalid appears the cycle after the
  // later of the AW/W handshakes.
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) w_state_d = W_RESP;
        else if (aw_hs)    w_state_d = W_WAIT_W;
        else if (w_hs)     w_state_d = W_WAIT_AW;
      end
      W_WAIT_W:  if (w_hs)  w_state_d = W_RESP;
      W_WAIT_AW: if (aw_hs) w_state_d = W_RESP;
      W_RESP:    if (b_hs)  w_state_d = W_IDLE;
      default:              w_state_d = W_IDLE;
    endcase

    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_WAIT_AW);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_WAIT_W);
    bvalid_d  = (w_state_d == W_RESP);
    bresp_d   = OKAY;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Read channel: single outstanding read, data is always zero.
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs) r_state_d = R_DATA;
      R_DATA:  if (r_hs)  r_state_d = R_IDLE;
      default:            r_state_d = R_IDLE;
    endcase

    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
    rresp_d   = OKAY;
    rdata_d   = '0;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= 2'b00;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
    end
  end

  assign axi4_s.awready = awready_q;
  assign axi4_s.wready  = wready_q;
  assign axi4_s.bvalid  = bvalid_q;
  assign axi4_s.bresp   = bresp_q;
  assign axi4_s.arready = arready_q;
  assign axi4_s.rvalid  = rvalid_q;
  assign axi4_s.rresp   = rresp_q;
  assign axi4_s.rdata   = rdata_q;

endmodule

// File: tb/tb_axi4_lite_terminus.sv
// Scoreboard bench for axi4_lite_terminus: expected responses are queued at
// the request handshake and checked when the response handshake completes.
module tb_axi4_lite_terminus;
  import axi4_lite_pkg::*;

  localparam axi4_lite_cfg_t CFG = '{default: 0, A: 16, N: 4};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_lite_if #(.C(CFG)) bus (.aclk(clk), .areset(rst));

  axi4_lite_terminus #(.C(CFG)) dut (
    .aclk  (clk),
    .areset(rst),
    .axi4_s(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Entries are {resp, data}; write responses carry zero data.
  logic [33:0] b_exp_q[$];
  logic [33:0] r_exp_q[$];
  logic [33:0] exp_v, got_v;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0;
    bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    checks++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b00000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b expected 00000",
               {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
    end
    checks++;
    if ({bus.bresp, bus.rresp, bus.rdata} !== 36'h0) begin
      failures++;
      $display("FAIL reset_data: got %h expected 0", {bus.bresp, bus.rresp, bus.rdata});
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.awready, bus.wready, bus.arready} !== 3'b000) begin
      failures++;
      $display("FAIL release_before_edge: got %b expected 000", {bus.awready, bus.wready, bus.arready});
    end
    step();
    checks++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b11100) begin
      failures++;
      $display("FAIL release_readies: got %b expected 11100",
               {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
    end
  endtask

  task automatic test_read(input logic [15:0] addr);
    bus.araddr = addr;
    bus.arprot = 3'($urandom_range(0, 7));
    bus.arvalid = 1'b1;
    bus.rready = 1'b1;
    checks++;
    if (bus.arready !== 1'b1) begin
      failures++;
      $display("FAIL read_arready: got %b expected 1", bus.arready);
    end
    r_exp_q.push_back({OKAY, 32'h0000_0000});
    step();
    bus.arvalid = 1'b0;
    checks++;
    if ({bus.arready, bus.rvalid} !== 2'b01) begin
      failures++;
      $display("FAIL read_latency: got arready,rvalid=%b expected 01", {bus.arready, bus.rvalid});
    end
    if (bus.rvalid === 1'b1) begin
      checks++;
      got_v = {bus.rresp, bus.rdata};
      if (r_exp_q.size() == 0) begin
        failures++;
        $display("FAIL read_resp: got unexpected rvalid data %h", got_v);
      end else begin
        exp_v = r_exp_q.pop_front();
        if (got_v !== exp_v) begin
          failures++;
          $display("FAIL read_resp: got %h expected %h", got_v, exp_v);
        end
      end
      $display("txn read  addr=%h rdata=%h rresp=%b", addr, bus.rdata, bus.rresp);
    end
    step();
    bus.rready = 1'b0;
    checks++;
    if ({bus.arready, bus.rvalid} !== 2'b10) begin
      failures++;
      $display("FAIL read_return_idle: got %b expected 10", {bus.arready, bus.rvalid});
    end
  endtask

  task automatic test_write_same(input logic [15:0] addr, input logic [31:0] data);
    bus.awaddr = addr; bus.awvalid = 1'b1;
    bus.wdata = data;  bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.bready = 1'b1;
    checks++;
    if ({bus.awready, bus.wready} !== 2'b11) begin
      failures++;
      $display("FAIL write_readies: got %b expected 11", {bus.awready, bus.wready});
    end
    b_exp_q.push_back({OKAY, 32'h0});
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    checks++;
    if ({bus.awready, bus.wready, bus.bvalid} !== 3'b001) begin
      failures++;
      $display("FAIL write_latency: got aw,w,b=%b expected 001", {bus.awready, bus.wready, bus.bvalid});
    end
    if (bus.bvalid === 1'b1) begin
      checks++;
      if (b_exp_q.size() == 0) begin
        failures++;
        $display("FAIL write_resp: got unexpected bvalid bresp=%b", bus.bresp);
      end else begin
        exp_v = b_exp_q.pop_front();
        if (bus.bresp !== exp_v[33:32]) begin
          failures++;
          $display("FAIL write_resp: got %b expected %b", bus.bresp, exp_v[33:32]);
        end
      end
      $display("txn write addr=%h data=%h bresp=%b", addr, data, bus.bresp);
    end
    step();
    bus.bready = 1'b0;
    checks++;
    if ({bus.awready, bus.wready, bus.bvalid} !== 3'b110) begin
      failures++;
      $display("FAIL write_return_idle: got %b expected 110", {bus.awready, bus.wready, bus.bvalid});
    end
  endtask

  task automatic test_aw_before_w();
    bus.awaddr = 16'h0010; bus.awvalid = 1'b1; bus.bready = 1'b1;
    step();
    bus.awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({bus.awready, bus.wready, bus.bvalid} !== 3'b010) begin
        failures++;
        $display("FAIL aw_first_wait[%0d]: got %b expected 010", i, {bus.awready, bus.wready, bus.bvalid});
      end
      if (i == 0) step();
    end
    bus.wdata = $urandom; bus.wstrb = 4'h3; bus.wvalid = 1'b1;
    b_exp_q.push_back({OKAY, 32'h0});
    step();
    bus.wvalid = 1'b0;
    checks++;
    if ((bus.bvalid !== 1'b1) || (b_exp_q.size() == 0)) begin
      failures++;
      $display("FAIL aw_first_resp: got bvalid=%b expected 1", bus.bvalid);
    end else begin
      exp_v = b_exp_q.pop_front();
      if (bus.bresp !== exp_v[33:32]) begin
        failures++;
        $display("FAIL aw_first_resp: got bresp=%b expected %b", bus.bresp, exp_v[33:32]);
      end
      $display("txn write addr=0010 aw-first bresp=%b", bus.bresp);
    end
    step();
    bus.bready = 1'b0;
  endtask

  task automatic test_w_before_aw();
    bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF; bus.wvalid = 1'b1; bus.bready = 1'b1;
    step();
    bus.wvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.awready, bus.wready, bus.bvalid} !== 3'b100) begin
        failures++;
        $display("FAIL w_first_wait[%0d]: got %b expected 100", i, {bus.awready, bus.wready, bus.bvalid});
      end
      if (i < 2) step();
    end
    bus.awaddr = 16'h0020; bus.awvalid = 1'b1;
    b_exp_q.push_back({OKAY, 32'h0});
    step();
    bus.awvalid = 1'b0;
    checks++;
    if ((bus.bvalid !== 1'b1) || (b_exp_q.size() == 0)) begin
      failures++;
      $display("FAIL w_first_resp: got bvalid=%b expected 1", bus.bvalid);
    end else begin
      exp_v = b_exp_q.pop_front();
      if (bus.bresp !== exp_v[33:32]) begin
        failures++;
        $display("FAIL w_first_resp: got bresp=%b expected %b", bus.bresp, exp_v[33:32]);
      end
      $display("txn write addr=0020 w-first bresp=%b", bus.bresp);
    end
    step();
    bus.bready = 1'b0;
    checks++;
    if ({bus.awready, bus.wready, bus.bvalid} !== 3'b110) begin
      failures++;
      $display("FAIL w_first_idle: got %b expected 110", {bus.awready, bus.wready, bus.bvalid});
    end
  endtask

  task automatic test_bready_stall();
    bus.awaddr = 16'h0030; bus.awvalid = 1'b1;
    bus.wdata = 32'hDEAD_0001; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.bready = 1'b0;
    b_exp_q.push_back({OKAY, 32'h0});
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.awready, bus.wready, bus.bvalid, bus.bresp} !== 5'b00100) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got aw,w,b,bresp=%b expected 00100", i,
                 {bus.awready, bus.wready, bus.bvalid, bus.bresp});
      end
      step();
    end
    bus.bready = 1'b1;
    checks++;
    if ((bus.bvalid !== 1'b1) || (b_exp_q.size() == 0)) begin
      failures++;
      $display("FAIL stall_resp: got bvalid=%b expected 1", bus.bvalid);
    end else begin
      exp_v = b_exp_q.pop_front();
      if (bus.bresp !== exp_v[33:32]) begin
        failures++;
        $display("FAIL stall_resp: got bresp=%b expected %b", bus.bresp, exp_v[33:32]);
      end
      $display("txn write addr=0030 stalled bresp=%b", bus.bresp);
    end
    step();
    bus.bready = 1'b0;
    checks++;
    if ({bus.awready, bus.wready, bus.bvalid} !== 3'b110) begin
      failures++;
      $display("FAIL stall_idle: got %b expected 110", {bus.awready, bus.wready, bus.bvalid});
    end
  endtask

  task automatic test_concurrent();
    bus.awaddr = 16'h0040; bus.awvalid = 1'b1;
    bus.wdata = 32'hCAFE_F00D; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = 16'h0044; bus.arvalid = 1'b1;
    bus.bready = 1'b1; bus.rready = 1'b1;
    b_exp_q.push_back({OKAY, 32'h0});
    r_exp_q.push_back({OKAY, 32'h0});
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    checks++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b00011) begin
      failures++;
      $display("FAIL concurrent_latency: got %b expected 00011",
               {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
    end
    if ((bus.bvalid === 1'b1) && (bus.rvalid === 1'b1)) begin
      checks++;
      if ((b_exp_q.size() == 0) || (r_exp_q.size() == 0)) begin
        failures++;
        $display("FAIL concurrent_resp: got responses with empty scoreboard");
      end else begin
        exp_v = b_exp_q.pop_front();
        got_v = r_exp_q.pop_front();
        if ({bus.bresp, bus.rresp, bus.rdata} !== {exp_v[33:32], got_v}) begin
          failures++;
          $display("FAIL concurrent_resp: got %h expected %h",
                   {bus.bresp, bus.rresp, bus.rdata}, {exp_v[33:32], got_v});
        end
      end
      $display("txn concurrent bresp=%b rresp=%b rdata=%h", bus.bresp, bus.rresp, bus.rdata);
    end
    step();
    bus.bready = 1'b0; bus.rready = 1'b0;
    checks++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b11100) begin
      failures++;
      $display("FAIL concurrent_idle: got %b expected 11100",
               {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
    end
  endtask

  task automatic test_back_to_back();
    bus.awvalid = 1'b1; bus.wvalid = 1'b1; bus.wstrb = 4'hF; bus.bready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.awaddr = 16'(k * 4);
      bus.wdata = $urandom;
      checks++;
      if ({bus.awready, bus.bvalid} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin
        failures++;
        $display("FAIL b2b_phase[%0d]: got awready,bvalid=%b", k, {bus.awready, bus.bvalid});
      end
      if ((bus.awready === 1'b1) && (bus.wready === 1'b1)) b_exp_q.push_back({OKAY, 32'h0});
      if (bus.bvalid === 1'b1) begin
        checks++;
        if (b_exp_q.size() == 0) begin
          failures++;
          $display("FAIL b2b_resp[%0d]: got unexpected bvalid", k);
        end else begin
          exp_v = b_exp_q.pop_front();
          if (bus.bresp !== exp_v[33:32]) begin
            failures++;
            $display("FAIL b2b_resp[%0d]: got %b expected %b", k, bus.bresp, exp_v[33:32]);
          end
        end
        $display("txn write b2b #%0d bresp=%b", k / 2, bus.bresp);
      end
      step();
    end
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.awaddr = 16'h0050; bus.awvalid = 1'b1;
    bus.wdata = 32'h5555_AAAA; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    bus.araddr = 16'h0054; bus.arvalid = 1'b1;
    bus.bready = 1'b0; bus.rready = 1'b0;
    step();
    bus.awvalid = 1'b0; bus.wvalid = 1'b0; bus.arvalid = 1'b0;
    step();
    checks++;
    if ({bus.bvalid, bus.bresp, bus.rvalid, bus.rresp, bus.rdata} !== {1'b1, OKAY, 1'b1, OKAY, 32'h0}) begin
      failures++;
      $display("FAIL rready_hold: got %h expected both valid with zero data",
               {bus.bvalid, bus.bresp, bus.rvalid, bus.rresp, bus.rdata});
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b00000) begin
      failures++;
      $display("FAIL midreset_drop: got %b expected 00000",
               {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
    end
    step();
    rst = 1'b0;
    bus.bready = 1'b1; bus.rready = 1'b1;
    step();
    checks++;
    if ({bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid} !== 5'b11100) begin
      failures++;
      $display("FAIL midreset_release: got %b expected 11100",
               {bus.awready, bus.wready, bus.arready, bus.bvalid, bus.rvalid});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bus.bvalid, bus.rvalid} !== 2'b00) begin
        failures++;
        $display("FAIL midreset_ghost[%0d]: got bvalid,rvalid=%b expected 00", i, {bus.bvalid, bus.rvalid});
      end
    end
    bus.bready = 1'b0; bus.rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_read(16'h0004);
    test_write_same(16'h0004, 32'hABBA_BEEF);
    test_read(16'h0004);
    test_aw_before_w();
    test_w_before_aw();
    test_bready_stall();
    test_concurrent();
    test_back_to_back();
    test_reset_mid();
    checks++;
    if ((b_exp_q.size() != 0) || (r_exp_q.size() != 0)) begin
      failures++;
      $display("FAIL scoreboard_drain: got b=%0d r=%0d pending expected 0",
               b_exp_q.size(), r_exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
